br_resolve_unit: RTL

- Downstream of the predictor top; closes the loop between fetch-time prediction and execute-time resolution.
- Buffers each in-flight prediction (PC, GHR snapshot, predicted direction and target) in an in-order queue.
- On resolution, produces registered gshare PHT update, BTB update and GHR-recovery commands, and flushes the queue on mispredict.
- Its outputs drive the predictor top's PHT write, BTB update (up_addr) and GHR restore (gshare_reen / re_GHR) inputs.

---
 rtl/br_resolve_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/br_resolve_unit.sv
// Branch resolution unit: queues in-flight predictions and, on in-order resolution, issues
// registered PHT/BTB update and GHR recovery commands, flushing the queue on a mispredict.
module br_resolve_unit #(
  parameter int unsigned GHR_W  = 14,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [ADDR_W-1:0]          pred_pc,
  input  logic [GHR_W-1:0]           pred_ghr,
  input  logic                       pred_taken,
  input  logic [ADDR_W-1:0]          pred_target,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [ADDR_W-1:0]          res_target,
  output logic                       upd_valid,
  output logic [GHR_W-1:0]           upd_idx,
  output logic                       upd_taken,
  output logic                       btb_upd_en,
  output logic [ADDR_W-1:0]          btb_upd_pc,
  output logic [ADDR_W-1:0]          btb_upd_target,
  output logic                       recover_en,
  output logic [GHR_W-1:0]           recover_ghr,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [GHR_W-1:0]  ghr_mem [DEPTH];
  logic              tkn_mem [DEPTH];
  logic [ADDR_W-1:0] tgt_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic              enq, res, mis, btb_wr;
  logic [ADDR_W-1:0] head_pc, head_tgt;
  logic [GHR_W-1:0]  head_ghr;
  logic              head_tkn;

  assign pred_ready = (count_q != Full);
  assign count      = count_q;

  assign head_pc  = pc_mem[rd_ptr_q];
  assign head_ghr = ghr_mem[rd_ptr_q];
  assign head_tkn = tkn_mem[rd_ptr_q];
  assign head_tgt = tgt_mem[rd_ptr_q];

  assign enq    = pred_valid && pred_ready;
  assign res    = res_valid && (count_q != '0);
  assign mis    = res && ((res_taken != head_tkn) ||
                          (res_taken && head_tkn && (res_target != head_tgt)));
  assign btb_wr = res && res_taken && (!head_tkn || (res_target != head_tgt));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mis) begin
      // Flush drops every younger entry, including any enqueue this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (res) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (enq && !res)      count_d = count_q + CntW'(1);
      else if (res && !enq) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !mis) begin
      pc_mem[wr_ptr_q]  <= pred_pc;
      ghr_mem[wr_ptr_q] <= pred_ghr;
      tkn_mem[wr_ptr_q] <= pred_taken;
      tgt_mem[wr_ptr_q] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      upd_valid      <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      btb_upd_en     <= 1'b0;
      btb_upd_pc     <= '0;
      btb_upd_target <= '0;
      recover_en     <= 1'b0;
      recover_ghr    <= '0;
      mispredict     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      upd_valid  <= res;
      btb_upd_en <= btb_wr;
      recover_en <= mis;
      mispredict <= mis;
      if (res) begin
        upd_idx        <= head_ghr ^ head_pc[GHR_W-1:0];
        upd_taken      <= res_taken;
        btb_upd_pc     <= head_pc;
        btb_upd_target <= res_target;
        recover_ghr    <= {head_ghr[GHR_W-2:0], res_taken};
      end
    end
  end

endmodule
